uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Frame-level controller on the output of the UART byte receiver (8-bit Data, Rx_Done strobe).
- Assembles 5-byte command frames and checks them; issues register-write strobes.
- Owns and drives the receiver's 3-bit baud_set, so a host can reconfigure the link rate over the link itself.
- Sits between the uart_byte_rx instance and the user register file.

Parameters:
- DEFAULT_BAUD, 3'd4, baud_set value after reset (4 = 115200).
- TIMEOUT_CYC, 50000, max Clk cycles between bytes inside a frame (1 ms at 50 MHz).
- HDR_BYTE, 8'h55, frame start byte.
- BAUD_ADDR, 8'hFF, reserved address that writes baud_set instead of the register file.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from receiver Data.
- rx_done  in  1  one-cycle strobe from receiver Rx_Done; rx_data valid in that cycle.
- baud_set  out  3  to receiver; 0=9600, 1=19200, 2=38400, 3=57600, 4=115200.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  8  write address, valid with wr_en.
- wr_data  out  16  write data, valid with wr_en.
- frame_err  out  1  one-cycle pulse on rejected frame.
- err_cnt  out  8  saturating count of rejected frames.
- busy  out  1  high while in any state except IDLE.

Behaviour:
- Clock and reset:
  - One clock (Clk). Reset is synchronous and active-high.
  - All state updates on posedge Clk.
  - Reset values: baud_set=DEFAULT_BAUD; wr_en=0, wr_addr=0, wr_data=0, frame_err=0, err_cnt=0, busy=0; FSM=IDLE; timeout counter=0.
  - Reset mid-frame discards the partial frame. No wr_en and no frame_err result from the discarded frame.
- Frame format: HDR, ADDR, DHI, DLO, CKS. CKS = (ADDR+DHI+DLO) mod 256.
- FSM states: IDLE, GET_ADDR, GET_DHI, GET_DLO, GET_CKS, COMMIT.
  - IDLE: rx_done with rx_data==HDR_BYTE -> GET_ADDR. Any other byte is ignored, with no error.
  - GET_ADDR, GET_DHI, GET_DLO: rx_done latches the byte into a shadow register and advances to the next state.
  - GET_CKS: on rx_done, compare rx_data with the computed sum.
    - Match -> COMMIT.
    - Mismatch -> IDLE, frame_err pulse.
  - COMMIT lasts one cycle, then -> IDLE.
    - If ADDR!=BAUD_ADDR: wr_en=1, wr_addr=ADDR, wr_data={DHI,DLO}.
    - If ADDR==BAUD_ADDR and DLO[7:3]==0 and DLO[2:0]<=4: baud_set<=DLO[2:0], no wr_en.
    - If ADDR==BAUD_ADDR and the value is invalid: frame_err, baud_set unchanged.
- Latency: wr_en is asserted exactly 2 cycles after the rx_done of the CKS byte. (Cycle N: CKS byte accepted. Cycle N+1: COMMIT computes outputs. Cycle N+2: registered outputs high.)
- baud_set change is visible the cycle after COMMIT. A new baud takes effect for the next frame; the controller does not wait or flush.
- Timeout:
  - Counter is cleared on every accepted rx_done and increments each cycle in GET_* states.
  - When the counter reaches TIMEOUT_CYC: -> IDLE, frame_err pulse.
  - If rx_done and expiry occur in the same cycle, the byte wins and the counter is cleared.
  - The counter does not run in IDLE.
- rx_done arriving in COMMIT is dropped. The receiver cannot produce two bytes 1 cycle apart, so this case is unreachable in normal operation.
- frame_err and wr_en are never both high in the same cycle.
- err_cnt increments on each frame_err and saturates at 255, with no wrap.
- wr_addr and wr_data hold their last value between strobes.

Decomposition:
- Package uart_cmd_pkg:
  - FSM state encoding.
  - Baud code constants: BAUD_9600 .. BAUD_115200 = 0..4, and BAUD_MAX=4.
  - Default HDR_BYTE and BAUD_ADDR.
- Sub-module uart_cmd_timeout: loadable inter-byte timeout counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Width: $clog2(TIMEOUT_CYC+1).
- The FSM, checksum and commit logic stay in the top module.

Test Plan:
- Bench setup: TIMEOUT_CYC=200. Bytes are driven through a real uart_byte_rx at baud 4, or via direct rx_done pulses where stated.
- Valid write: frame 55 12 AB CD 8A -> one wr_en pulse, wr_addr=8'h12, wr_data=16'hABCD, 2 cycles after the last rx_done; frame_err=0; err_cnt=0.
- Bad checksum: frame 55 12 AB CD 8B -> no wr_en, one frame_err pulse, err_cnt=1. The immediately following valid frame 55 01 00 02 03 still writes addr 01 with data 0002.
- Noise and timeout:
  - Bytes 00 7F before the header are ignored silently.
  - Frame 55 20 then silence for 200 cycles -> frame_err at count 200, busy drops, err_cnt increments.
  - Same-cycle rx_done at count 200 -> no error.
- Baud reconfiguration:
  - 55 FF 00 02 01 -> baud_set goes 4->2, no wr_en.
  - Then 55 FF 00 07 06 -> frame_err, baud_set stays 2.
- Reset mid-frame: Reset pulsed after 55 33 AA -> busy=0, baud_set=4, no wr_en and no frame_err. A fresh frame afterwards works.
- Saturation: 260 bad-checksum frames (direct rx_done drive) -> err_cnt=255 and held.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetDhi,
        StGetDlo,
        StGetCks,
        StCommit
    } state_e;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_MAX    = BAUD_115200;

    localparam logic [7:0] DEF_HDR_BYTE  = 8'h55;
    localparam logic [7:0] DEF_BAUD_ADDR = 8'hFF;

    function automatic logic [7:0] frame_cks(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction

    // A baud byte is only accepted if the upper bits are clear and the code is in range.
    function automatic logic baud_valid(input logic [7:0] v);
        return (v[7:3] == 5'd0) && (v[2:0] <= BAUD_MAX);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled, saturates at the limit.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level command controller: assembles HDR/ADDR/DHI/DLO/CKS frames from the byte
// receiver, issues register writes, and owns the receiver's baud_set.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [2:0]  DEFAULT_BAUD = BAUD_115200,
    parameter int unsigned TIMEOUT_CYC  = 50000,
    parameter logic [7:0]  HDR_BYTE     = DEF_HDR_BYTE,
    parameter logic [7:0]  BAUD_ADDR    = DEF_BAUD_ADDR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [2:0]  baud_set,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    state_e     state_q;
    logic [7:0] addr_q, dhi_q, dlo_q;
    logic       in_get;
    logic       to_clear;
    logic       expired;

    assign in_get   = (state_q == StGetAddr) || (state_q == StGetDhi) ||
                      (state_q == StGetDlo) || (state_q == StGetCks);
    // Clearing outside GET_* guarantees every frame starts its first gap from zero.
    assign to_clear = rx_done || !in_get;

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (to_clear),
        .enable  (in_get),
        .expired (expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            baud_set  <= DEFAULT_BAUD;
            wr_en     <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 16'h0000;
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
            addr_q    <= 8'h00;
            dhi_q     <= 8'h00;
            dlo_q     <= 8'h00;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            if (frame_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            case (state_q)
                StIdle: begin
                    if (rx_done && (rx_data == HDR_BYTE)) begin
                        state_q <= StGetAddr;
                        busy    <= 1'b1;
                    end
                end
                StGetAddr, StGetDhi, StGetDlo: begin
                    if (rx_done) begin
                        if (state_q == StGetAddr) begin
                            addr_q  <= rx_data;
                            state_q <= StGetDhi;
                        end else if (state_q == StGetDhi) begin
                            dhi_q   <= rx_data;
                            state_q <= StGetDlo;
                        end else begin
                            dlo_q   <= rx_data;
                            state_q <= StGetCks;
                        end
                    end else if (expired) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                StGetCks: begin
                    if (rx_done) begin
                        if (rx_data == frame_cks(addr_q, dhi_q, dlo_q)) begin
                            state_q <= StCommit;
                        end else begin
                            state_q   <= StIdle;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end else if (expired) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    if (addr_q != BAUD_ADDR) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= {dhi_q, dlo_q};
                    end else if (baud_valid(dlo_q)) begin
                        baud_set <= dlo_q[2:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame table, scoreboard monitor, corner sequences.
module tb_uart_cmd_ctrl;

    typedef enum int {K_WR, K_CKS, K_BAUD, K_BADBAUD} kind_e;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] dhi;
        logic [7:0] dlo;
        logic       bad_cks;
        kind_e      kind;
        logic [2:0] baud;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [2:0]  baud_set;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          err_pending = 0;
    logic [23:0] wr_q[$];
    logic [7:0]  exp_errcnt = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    logic [15:0] last_data = 16'h0000;
    vec_t        vecs[12];

    always #10 Clk = ~Clk;

    uart_cmd_ctrl #(
        .DEFAULT_BAUD (3'd4),
        .TIMEOUT_CYC  (200),
        .HDR_BYTE     (8'h55),
        .BAUD_ADDR    (8'hFF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .baud_set  (baud_set),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every wr_en / frame_err pulse must match an expectation queued by stimulus.
    always @(negedge Clk) begin
        if (wr_en) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_wr: addr=%h data=%h with none expected", wr_addr, wr_data);
            end else begin
                logic [23:0] e;
                e = wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_errors++;
                    $display("FAIL wr_payload: got %h_%h expected %h_%h", wr_addr, wr_data,
                             e[23:16], e[15:0]);
                end
            end
        end
        if (frame_err) begin
            n_checks++;
            if (err_pending == 0) begin
                n_errors++;
                $display("FAIL unexpected_frame_err: got 1 expected 0");
            end else begin
                err_pending--;
            end
        end
        if (wr_en && frame_err) begin
            n_errors++;
            $display("FAIL wr_and_err_overlap: got both high expected exclusive");
        end
    end

    task automatic pulse(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge Clk);
        rx_done = 1'b0;
    endtask

    task automatic expect_err();
        err_pending++;
        if (exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] cks;
        cks = v.addr + v.dhi + v.dlo + {7'd0, v.bad_cks};
        if (v.kind == K_WR) begin
            wr_q.push_back({v.addr, v.dhi, v.dlo});
            last_addr = v.addr;
            last_data = {v.dhi, v.dlo};
        end else if (v.kind != K_BAUD) begin
            expect_err();
        end
        pulse(8'h55);
        repeat (2) @(negedge Clk);
        pulse(v.addr);
        repeat (2) @(negedge Clk);
        pulse(v.dhi);
        repeat (2) @(negedge Clk);
        pulse(v.dlo);
        repeat (2) @(negedge Clk);
        pulse(cks);
        check("wr_en_n1", {31'd0, wr_en}, 32'd0);
        check("frame_err_n1", {31'd0, frame_err}, {31'd0, v.kind == K_CKS});
        @(negedge Clk);
        check("wr_en_n2", {31'd0, wr_en}, {31'd0, v.kind == K_WR});
        check("frame_err_n2", {31'd0, frame_err}, {31'd0, v.kind == K_BADBAUD});
        check("baud_set", {29'd0, baud_set}, {29'd0, v.baud});
        repeat (2) @(negedge Clk);
        check("err_cnt", {24'd0, err_cnt}, {24'd0, exp_errcnt});
        check("busy_after", {31'd0, busy}, 32'd0);
        check("wr_hold", {8'd0, wr_addr, wr_data}, {8'd0, last_addr, last_data});
    endtask

    initial begin
        int waited;
        logic seen;
        vec_t v;

        vecs[0]  = '{8'h12, 8'hAB, 8'hCD, 1'b0, K_WR,      3'd4};
        vecs[1]  = '{8'h12, 8'hAB, 8'hCD, 1'b1, K_CKS,     3'd4};
        vecs[2]  = '{8'h01, 8'h00, 8'h02, 1'b0, K_WR,      3'd4};
        vecs[3]  = '{8'h00, 8'hFF, 8'hFF, 1'b0, K_WR,      3'd4};
        vecs[4]  = '{8'hFF, 8'h00, 8'h02, 1'b0, K_BAUD,    3'd2};
        vecs[5]  = '{8'hFF, 8'h00, 8'h07, 1'b0, K_BADBAUD, 3'd2};
        vecs[6]  = '{8'hFF, 8'h00, 8'h0C, 1'b0, K_BADBAUD, 3'd2};
        vecs[7]  = '{8'hFF, 8'h00, 8'h00, 1'b0, K_BAUD,    3'd0};
        vecs[8]  = '{8'hFF, 8'h00, 8'h04, 1'b0, K_BAUD,    3'd4};
        vecs[9]  = '{8'hFF, 8'h00, 8'h05, 1'b0, K_BADBAUD, 3'd4};
        vecs[10] = '{8'hFF, 8'h12, 8'h03, 1'b0, K_BAUD,    3'd3};
        vecs[11] = '{8'hFE, 8'h11, 8'h22, 1'b0, K_WR,      3'd3};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_baud", {29'd0, baud_set}, 32'd4);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i]);
        end

        // Noise ahead of a header is dropped silently.
        pulse(8'h00);
        repeat (2) @(negedge Clk);
        pulse(8'h7F);
        repeat (2) @(negedge Clk);
        check("noise_busy", {31'd0, busy}, 32'd0);
        v = '{8'h01, 8'h00, 8'h02, 1'b0, K_WR, 3'd3};
        send_frame(v);

        // Timeout: silence after ADDR expires at count 200, error one cycle later.
        pulse(8'h55);
        repeat (2) @(negedge Clk);
        pulse(8'h20);
        expect_err();
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge Clk);
            waited++;
            if (frame_err) seen = 1'b1;
        end
        check("timeout_latency", waited, 201);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge Clk);
        check("timeout_err_cnt", {24'd0, err_cnt}, {24'd0, exp_errcnt});

        // Byte arriving in the very cycle the counter hits the limit wins.
        pulse(8'h55);
        repeat (2) @(negedge Clk);
        pulse(8'h20);
        repeat (200) @(negedge Clk);
        check("edge_busy_before", {31'd0, busy}, 32'd1);
        pulse(8'hAB);
        check("edge_busy_after", {31'd0, busy}, 32'd1);
        wr_q.push_back({8'h20, 8'hAB, 8'h01});
        last_addr = 8'h20;
        last_data = 16'hAB01;
        repeat (2) @(negedge Clk);
        pulse(8'h01);
        repeat (2) @(negedge Clk);
        pulse(8'hCC);
        repeat (3) @(negedge Clk);
        check("edge_wr_drained", wr_q.size(), 0);
        check("edge_err_cnt", {24'd0, err_cnt}, {24'd0, exp_errcnt});

        // Reset mid-frame discards the partial frame and restores defaults.
        pulse(8'h55);
        repeat (2) @(negedge Clk);
        pulse(8'h33);
        repeat (2) @(negedge Clk);
        pulse(8'hAA);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_errcnt = 8'h00;
        last_addr = 8'h00;
        last_data = 16'h0000;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_baud", {29'd0, baud_set}, 32'd4);
        repeat (5) @(negedge Clk);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        v = '{8'h33, 8'hAA, 8'hBB, 1'b0, K_WR, 3'd4};
        send_frame(v);

        // Saturation of the error counter.
        v = '{8'h12, 8'hAB, 8'hCD, 1'b1, K_CKS, 3'd4};
        for (int i = 0; i < 260; i++) begin
            send_frame(v);
        end
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

        repeat (5) @(negedge Clk);
        check("wr_queue_empty", wr_q.size(), 0);
        check("err_pending_zero", err_pending, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
